// File: rtl/stos_ext.sv
// stos_ext: parametrised LIFO stack with replace-top (push+pop), registered
// top-of-stack view, occupancy count, almost-full threshold and sticky
// overflow/underflow flags cleared by err_clr.
// Optional build macro STOS_HIGH_WATER_EN enables the high_water tracker;
// without it high_water is tied to zero and no tracking register exists.
module stos_ext #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 32,
    parameter int AF_THRESH = DEPTH - 2,
    localparam int CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_in,
    input  logic              err_clr,
    output logic [DATA_W-1:0] top,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              overflow,
    output logic              underflow,
    output logic [CNT_W-1:0]  high_water
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
    localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

    // Storage is never reset; entries above count are unreachable anyway.
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [CNT_W-1:0]  r_count;
    logic              r_overflow;
    logic              r_underflow;

    logic [CNT_W-1:0]  w_count_nxt;
    logic [AW-1:0]     w_rd_idx;
    logic [AW-1:0]     w_wr_idx;
    logic [AW-1:0]     w_waddr;
    logic              w_we;
    logic              w_full;
    logic              w_empty;
    logic              w_ovf_set;
    logic              w_udf_set;

    // Status is decoded from the count register only, never from inputs.
    assign w_full   = (r_count == DEPTH_C);
    assign w_empty  = (r_count == '0);
    assign w_rd_idx = AW'(r_count - ONE_C);
    assign w_wr_idx = AW'(r_count);

    // Next-state decode: write slot, next count and error events.
    always_comb begin
        w_count_nxt = r_count;
        w_we        = 1'b0;
        w_waddr     = w_wr_idx;
        w_ovf_set   = 1'b0;
        w_udf_set   = 1'b0;
        unique case ({push, pop})
            2'b10: begin
                if (w_full) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_we        = 1'b1;
                    w_waddr     = w_wr_idx;
                    w_count_nxt = r_count + ONE_C;
                end
            end
            2'b01: begin
                if (w_empty) begin
                    w_udf_set = 1'b1;
                end else begin
                    w_count_nxt = r_count - ONE_C;
                end
            end
            2'b11: begin
                // Replace-top; on an empty stack this degenerates to a push.
                w_we = 1'b1;
                if (w_empty) begin
                    w_waddr     = '0;
                    w_count_nxt = ONE_C;
                end else begin
                    w_waddr = w_rd_idx;
                end
            end
            default: begin
                w_count_nxt = r_count;
            end
        endcase
        // Reset discards the operation entirely, including the write.
        if (rst) begin
            w_we = 1'b0;
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= data_in;
        end
    end

    // Count and sticky error flags; a new error event beats err_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_count     <= w_count_nxt;
            r_overflow  <= w_ovf_set | (r_overflow  & ~err_clr);
            r_underflow <= w_udf_set | (r_underflow & ~err_clr);
        end
    end

`ifdef STOS_HIGH_WATER_EN
    logic [CNT_W-1:0] r_high_water;

    // Peak occupancy since reset or the last err_clr, tracking next count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_high_water <= '0;
        end else if (err_clr) begin
            r_high_water <= w_count_nxt;
        end else if (w_count_nxt > r_high_water) begin
            r_high_water <= w_count_nxt;
        end
    end

    assign high_water = r_high_water;
`else
    assign high_water = '0;
`endif

    assign top         = w_empty ? '0 : r_mem[w_rd_idx];
    assign count       = r_count;
    assign full        = w_full;
    assign empty       = w_empty;
    assign almost_full = (r_count >= AF_C);
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule

// File: doc/stos_ext.md
Name: stos_ext

Overview:
- Parametrised LIFO stack for the microprocessor datapath; successor to the basic 8-bit/32-entry stack.
- Adds simultaneous push+pop (replace-top), an always-visible top-of-stack, an occupancy count, an almost-full threshold, and sticky overflow/underflow error flags with clear.
- Serves as the call/return stack and the data stack, so width and depth differ per instance.

Parameters:
- DATA_W, 8: width of one stack entry in bits (>=1).
- DEPTH, 32: number of entries (>=2; any value, not restricted to powers of two).
- AF_THRESH, DEPTH-2: count at or above which almost_full asserts (1..DEPTH).
- CNT_W, $clog2(DEPTH+1): width of count; derived, not overridden.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- push  in  1  write data_in onto stack this cycle
- pop  in  1  remove top entry this cycle
- data_in  in  DATA_W  value to push
- err_clr  in  1  clears sticky overflow/underflow flags
- top  out  DATA_W  current top entry (mem[count-1]); 0 when empty
- count  out  CNT_W  number of valid entries, 0..DEPTH
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_THRESH
- overflow  out  1  sticky: push attempted while full without pop
- underflow  out  1  sticky: pop attempted while empty without push
- high_water  out  CNT_W  maximum count reached (optional feature; see below)

Behaviour:
- Reset (rst=1 at clk edge) overrides all other inputs. After the edge: count=0, empty=1, full=0, almost_full=0, overflow=0, underflow=0, top=0, high_water=0. Memory contents are not cleared; they are unobservable while empty.
- A reset asserted mid-sequence discards all entries on that edge, with no partial operation.
- count is the only pointer. The write slot is mem[count]; top reads mem[count-1].
- full, empty and almost_full are pure functions of the count register, so they change in the same cycle as count. No input-to-output combinational paths exist except none: top depends only on registered state.
- Latency: an operation sampled at edge n is reflected on top, count and flags immediately after edge n (1-cycle). top is never gated by pop.
- Push only, not full: mem[count] <= data_in; count+1.
- Push only, full: ignored (count and mem unchanged); overflow <= 1.
- Pop only, not empty: count-1; the old top value becomes unreachable.
- Pop only, empty: ignored; underflow <= 1.
- Push+pop, count>=1 (including full): replace-top. mem[count-1] <= data_in; count unchanged; no error flag.
- Push+pop, empty: behaves as push only (count becomes 1, top=data_in); underflow is not set.
- Neither push nor pop: hold.
- err_clr=1 clears overflow and underflow on the edge. If an error event occurs in the same cycle, the set wins (flag reads 1 afterwards).
- Arithmetic: count never wraps. It saturates logically at 0 and DEPTH through the ignore rules above; no modular pointer arithmetic is used.

Optional Feature:
- Macro: STOS_HIGH_WATER_EN.
- Defined: high_water is a register tracking the maximum count value since reset or the last err_clr. On err_clr, high_water loads the current next-state count. It updates on the same edge as count.
- Undefined: high_water is driven constant 0 and no tracking register is synthesised. All other behaviour is identical.

Test Plan (DATA_W=8, DEPTH=4, AF_THRESH=3):
- Reset, then push 0x11,0x22,0x33,0x44 on consecutive cycles. Expect count 1,2,3,4; top 0x11,0x22,0x33,0x44; almost_full=1 from count 3; full=1 at count 4; empty=0 after the first push.
- Push 0x55 while full. Expect count=4, top=0x44, overflow=1 and held. Then err_clr=1 for one cycle: overflow=0. Then push+pop with 0x66 while full: top=0x66, count=4, overflow stays 0.
- Pop 4 times from [0x11,0x22,0x33,0x66]. Expect top 0x33,0x22,0x11,0x00 and count 3,2,1,0; empty=1 at the end. A 5th pop gives underflow=1 with count=0.
- On empty: push+pop with 0xA5. Expect count=1, top=0xA5, underflow unchanged (0 after clear). Then err_clr coincident with pop-on-empty after popping: underflow=1 (set wins).
- Push 0x01,0x02, then assert rst together with push=1 and data 0x03. Expect count=0, empty=1, top=0, all flags 0 the next cycle; the push is not performed.
- STOS_HIGH_WATER_EN defined: push 3, pop 2, push 1. Expect high_water=3 while count=2. Then err_clr: high_water=2. With the macro undefined, high_water=0 throughout.
